// File: rtl/mux_scan_pkg.sv
// Shared encodings and sizes for the scanned 4:1 mux capture controller.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Select/sample/handshake bundle between the scan controller and its environment.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              START;
  logic              CONT;
  logic              SEL0;
  logic              SEL1;
  logic              MUX_OUT;
  logic [NUM_CH-1:0] WORD;
  logic              VALID;
  logic              READY;
  logic              BUSY;

  modport master (
    input  START, CONT, MUX_OUT, READY,
    output SEL0, SEL1, WORD, VALID, BUSY
  );

  modport slave (
    output START, CONT, MUX_OUT, READY,
    input  SEL0, SEL1, WORD, VALID, BUSY
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Per-channel settle counter: done is high in the last cycle of a channel window.
module settle_timer #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done = (cnt_q == CNT_W'(SETTLE));

  // Wraps to zero on done so back-to-back windows need no explicit clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, samples each after settling,
// and offers the assembled word downstream over VALID/READY.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  mux_scan_ctrl_if.master bus
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [IDX_W-1:0]  sel_q,   sel_d;
  logic [NUM_CH-1:0] word_q,  word_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;

  logic timer_clear;
  logic timer_en;
  logic timer_done;

  settle_timer #(
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) u_settle_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (timer_clear),
    .enable (timer_en),
    .done   (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    word_d      = word_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d     = SCAN;
          idx_d       = '0;
          sel_d       = '0;
          busy_d      = 1'b1;
          timer_clear = 1'b1;
        end
      end

      SCAN: begin
        timer_en = 1'b1;
        if (timer_done) begin
          word_d[idx_q] = bus.MUX_OUT;
          idx_d         = idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = HOLD;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            sel_d   = '0;
          end else begin
            sel_d = idx_q + 1'b1;
          end
        end
      end

      HOLD: begin
        // In continuous mode the handshake edge doubles as the next start.
        if (bus.READY) begin
          valid_d = 1'b0;
          if (bus.CONT) begin
            state_d     = SCAN;
            idx_d       = '0;
            sel_d       = '0;
            busy_d      = 1'b1;
            timer_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.SEL0  = sel_q[0];
  assign bus.SEL1  = sel_q[1];
  assign bus.WORD  = word_q;
  assign bus.VALID = valid_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequential front/back stage for the 4:1 mux (mux4_1). It drives SEL0/SEL1 through all four channels, waits a programmable settle time per channel, and samples the mux OUT. It assembles the four samples into a 4-bit word and hands it downstream over a VALID/READY handshake. It turns the combinational mux into a scanned, registered 4-channel capture path.

Parameters:
SETTLE, 1, extra cycles SEL is held before sampling; each channel occupies SETTLE+1 cycles; legal range 0..15.
CNT_W, 4, width of the settle counter; must hold SETTLE.

Ports:
CLK  input  1  single system clock; all logic on rising edge.
RST_N  input  1  reset, synchronous, active-low.
START  input  1  request one scan; sampled only in IDLE.
CONT  input  1  continuous mode; when 1, a new scan begins on the handshake edge.
SEL0  output  1  mux select bit 0 = channel index bit 0.
SEL1  output  1  mux select bit 1 = channel index bit 1.
MUX_OUT  input  1  mux OUT, sampled at the end of each channel window.
WORD  output  4  captured word; WORD[k] = sample of channel k (k = {SEL1,SEL0}; 0=A, 1=B, 2=C, 3=D).
VALID  output  1  WORD is complete and stable.
READY  input  1  downstream accepts WORD.
BUSY  output  1  scan in progress (SCAN state).

Behaviour:
- Reset is synchronous: RST_N=0 at a rising edge sets state=IDLE, SEL0=SEL1=0, WORD=0, VALID=0, BUSY=0, idx=0, cnt=0. Reset mid-scan or mid-hold aborts; no partial word is kept.
- States: IDLE, SCAN, HOLD. All outputs are registered.
- IDLE: SEL=00, BUSY=0, VALID=0.
  - START=1 at an edge -> SCAN, idx=0, cnt=0, BUSY=1.
  - WORD keeps its last value.
- SCAN: {SEL1,SEL0}=idx throughout the channel window.
  - cnt increments each cycle. At the edge where cnt==SETTLE: WORD[idx] <= MUX_OUT, cnt <= 0, idx <= idx+1.
  - Other WORD bits are unchanged during the scan.
  - At the edge sampling idx==3: -> HOLD, VALID=1, BUSY=0, SEL=00.
- Latency: START edge -> VALID high after exactly 4*(SETTLE+1) edges. SETTLE=1 gives 8; SETTLE=0 gives 4.
- HOLD: VALID=1, WORD held stable until the handshake. The handshake is VALID=1 and READY=1 at an edge.
  - On handshake with CONT=0: -> IDLE, VALID=0.
  - On handshake with CONT=1: -> SCAN, idx=0, cnt=0, VALID=0, BUSY=1. There is no idle bubble.
  - READY=0 holds indefinitely (backpressure); nothing is lost or overwritten.
- START while in SCAN or HOLD is ignored; there is no queuing.
- CONT is sampled only on the handshake edge. Holding CONT=1 in IDLE does not start a scan; START is still required.
- READY outside HOLD is ignored.
- MUX_OUT is captured as-is, including X/Z in simulation; there is no filtering.
- Counter widths: idx is 2 bits and wraps 3->0, but the wrap is only reached through HOLD. cnt is CNT_W bits and never exceeds SETTLE.

Decomposition:
- Shared package/include mux_scan_pkg holds:
  - state encoding: IDLE=2'd0, SCAN=2'd1, HOLD=2'd2;
  - localparam NUM_CH=4;
  - localparam IDX_W=2.
- One sub-module, settle_timer (CNT_W counter). Inputs: clear, enable. Output: done when cnt==SETTLE. Reused per channel window.
- The state machine, idx and WORD register stay in mux_scan_ctrl.

Test Plan:
- Basic capture, SETTLE=1: mux with A=1 B=0 C=1 D=1, START pulse, READY=1. Required: SEL steps 00,01,10,11, each held 2 cycles; VALID rises 8 edges after START; WORD=4'b1101; returns to IDLE next edge.
- Backpressure: same inputs, READY=0 for 20 cycles after VALID. Required: VALID and WORD=4'b1101 stay stable for 20 cycles; START pulses in that window are ignored; READY=1 gives VALID=0 on the next edge.
- Continuous mode, SETTLE=0: CONT=1, READY=1. Drive A..D=0000 for scan 1, then 1111 before scan 2 starts. Required: VALID is a 1-cycle pulse every 5 cycles (4 scan + 1 hold); WORD=0000 then 1111; BUSY is never low for more than 1 cycle.
- Exhaustive: drive {A,B,C,D}=i for i=0..15, one scan each. Required: WORD == {D,C,B,A} for every i.
- Reset mid-scan: RST_N=0 while idx=2. Required: at the next edge SEL=00, BUSY=0, VALID=0, WORD=0; a new START produces a correct full scan.
- START during SCAN: a second START pulse at scan cycle 3. Required: exactly one VALID per scan; the latency is unchanged.
